// File: rtl/counter_clock_ctrl.sv
// counter_clock_ctrl: board clock divider plus debounced direction toggle.
// Define SINGLE_STEP_EN to add the debounced single-step button step_btn_n.
module counter_clock_ctrl #(
  parameter int DIV_HALF        = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic dir_btn_n,
`ifdef SINGLE_STEP_EN
  input  logic step_btn_n,
`endif
  output logic clock_div,
  output logic Up_Down,
  output logic tick
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int BW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV_HALF - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);

`ifdef SINGLE_STEP_EN
  localparam int NB = 2;
  logic [NB-1:0] btn_n;
  assign btn_n = {step_btn_n, dir_btn_n};
`else
  localparam int NB = 1;
  logic [NB-1:0] btn_n;
  assign btn_n = dir_btn_n;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } deb_state_t;

  logic [NB-1:0] accept;

  for (genvar g = 0; g < NB; g++) begin : g_deb
    deb_state_t    state;
    deb_state_t    state_nx;
    logic [BW-1:0] cnt;
    logic [BW-1:0] cnt_nx;
    logic [1:0]    sync;
    logic          pressed;
    logic          acc;

    assign pressed   = ~sync[1];
    assign accept[g] = acc;

    // Two-flop synchronizer for the raw button level
    always_ff @(posedge clock) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], btn_n[g]};
    end

    // Debounce state and stable-level counter
    always_ff @(posedge clock) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // Accept a press once per press/release cycle
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      acc      = 1'b0;
      unique case (state)
        IDLE: begin
          if (pressed) begin
            state_nx = PRESS_WAIT;
            cnt_nx   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed) begin
            state_nx = IDLE;
          end else if (cnt == DEB_LAST) begin
            state_nx = HELD;
            acc      = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!pressed) begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed) begin
            state_nx = HELD;
          end else if (cnt == DEB_LAST) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  logic [DW-1:0] div_cnt;
  logic          wrap;
  logic          step_go;
  logic          rise;
  logic          apply;
  logic          pending;

  assign wrap = div_cnt == DIV_LAST;

`ifdef SINGLE_STEP_EN
  // a high clock_div means a pulse is already in flight
  assign step_go = accept[1] & ~run & ~clock_div;
`else
  assign step_go = 1'b0;
`endif

  assign rise  = (~clock_div & run & wrap) | step_go;
  assign apply = pending & ~clock_div & ~rise;

  // Divider: a high phase always completes, low phase parks when idle
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      clock_div <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= rise;
      if (step_go) begin
        div_cnt   <= '0;
        clock_div <= 1'b1;
      end else if (run | clock_div) begin
        if (wrap) begin
          div_cnt   <= '0;
          clock_div <= ~clock_div;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        div_cnt <= '0;
      end
    end
  end

  // Direction toggles only while clock_div is low and stays low
  always_ff @(posedge clock) begin
    if (reset) begin
      Up_Down <= 1'b1;
      pending <= 1'b0;
    end else begin
      if (apply) Up_Down <= ~Up_Down;
      pending <= (pending & ~apply) ^ accept[0];
    end
  end

endmodule

// File: tb/tb_counter_clock_ctrl.sv
// tb_counter_clock_ctrl: scoreboard bench for counter_clock_ctrl.
// Reference model tracks waveform phase and button run lengths.
module tb_counter_clock_ctrl;

  localparam int DH = 4;
  localparam int DB = 8;

  logic clock     = 1'b0;
  logic reset     = 1'b1;
  logic run       = 1'b0;
  logic dir_btn_n = 1'b1;
`ifdef SINGLE_STEP_EN
  logic step_btn_n = 1'b1;
`endif
  logic clock_div;
  logic Up_Down;
  logic tick;

  int checks     = 0;
  int errors     = 0;
  int ud_changes = 0;

  counter_clock_ctrl #(
    .DIV_HALF(DH),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .run(run),
    .dir_btn_n(dir_btn_n),
`ifdef SINGLE_STEP_EN
    .step_btn_n(step_btn_n),
`endif
    .clock_div(clock_div),
    .Up_Down(Up_Down),
    .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic clk;
    logic ud;
    logic tk;
  } exp_t;

  exp_t     expq[$];
  int       phase  = 0;
  bit       m_ud   = 1'b1;
  bit       m_tick = 1'b0;
  bit       pend   = 1'b0;
  bit [1:0] hist[2];
  bit       held[2];
  int       runlen[2];

  task automatic model_reset();
    phase  = 0;
    m_ud   = 1'b1;
    m_tick = 1'b0;
    pend   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      hist[c]   = 2'b11;
      held[c]   = 1'b0;
      runlen[c] = 0;
    end
  endtask

  // a press counts after DB+1 consecutive synced lows from released,
  // release needs DB+1 consecutive synced highs
  function automatic bit deb_step(input int ch, input bit btn);
    bit lvl;
    bit a;
    a = 1'b0;
    lvl = hist[ch][1];
    hist[ch] = {hist[ch][0], btn};
    if (lvl == held[ch]) runlen[ch]++;
    else runlen[ch] = 0;
    if (runlen[ch] == DB + 1) begin
      a = !held[ch];
      held[ch] = !held[ch];
      runlen[ch] = 0;
    end
    return a;
  endfunction

  always @(posedge clock) begin : model_p
    bit old_high;
    bit new_high;
    bit rise;
    bit apply;
    bit acc;
    bit sacc;
    old_high = phase >= DH;
    acc = deb_step(0, dir_btn_n);
`ifdef SINGLE_STEP_EN
    sacc = deb_step(1, step_btn_n);
`else
    sacc = 1'b0;
`endif
    if (sacc && !run && !old_high) phase = DH;
    else if (run || old_high) phase = (phase + 1) % (2 * DH);
    else phase = 0;
    new_high = phase >= DH;
    rise = new_high && !old_high;
    apply = pend && !old_high && !rise;
    if (apply) m_ud = !m_ud;
    pend = (pend && !apply) ^ acc;
    m_tick = rise;
    if (reset) model_reset();
    expq.push_back(exp_t'({phase >= DH, m_ud, m_tick}));
  end

  // ---------------- monitor ----------------
  logic prev_ud = 1'b1;

  always @(negedge clock) begin : monitor_p
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("clock_div", clock_div, e.clk);
      check("Up_Down", Up_Down, e.ud);
      check("tick", tick, e.tk);
      if (Up_Down !== prev_ud) begin
        ud_changes++;
        check("ud_change_while_low", clock_div, 0);
      end
      prev_ud = Up_Down;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (tick !== 1'b1 && n < limit);
  endtask

  initial begin
    int n;
    int c0;
    int hi;
    int tk;
    int nb;

    // reset and first waveform
    reset = 1'b1;
    run   = 1'b0;
    cyc(2);
    check("rst_clock_div", clock_div, 0);
    check("rst_Up_Down", Up_Down, 1);
    check("rst_tick", tick, 0);
    reset = 1'b0;
    run   = 1'b1;
    wait_tick(50, n);
    check("first_rise", n, DH);
    wait_tick(50, n);
    check("period", n, 2 * DH);

    // short press ignored, long press toggles once
    dir_btn_n = 1'b0;
    cyc(5);
    dir_btn_n = 1'b1;
    cyc(30);
    check("short_press_no_toggle", Up_Down, 1);
    c0 = ud_changes;
    dir_btn_n = 1'b0;
    cyc(20);
    dir_btn_n = 1'b1;
    cyc(30);
    check("press_dir", Up_Down, 0);
    check("press_one_toggle", ud_changes - c0, 1);

    // long hold with bouncy release
    c0 = ud_changes;
    dir_btn_n = 1'b0;
    cyc(200);
    repeat (4) begin
      dir_btn_n = 1'b1;
      cyc(3);
      dir_btn_n = 1'b0;
      cyc(3);
    end
    dir_btn_n = 1'b1;
    cyc(40);
    check("hold_one_toggle", ud_changes - c0, 1);
    check("hold_dir", Up_Down, 1);

    // run drop one cycle into a high phase
    wait_tick(50, n);
    run = 1'b0;
    hi = 0;
    tk = 0;
    repeat (30) begin
      cyc(1);
      hi += int'(clock_div);
      tk += int'(tick);
    end
    check("park_high_cycles", hi, DH - 1);
    check("park_no_tick", tk, 0);
    check("park_low", clock_div, 0);
    run = 1'b1;
    wait_tick(50, n);
    check("restart_rise", n, DH);

    // reset while high with a press pending
    cyc(20);
    wait_tick(50, n);
    dir_btn_n = 1'b0;
    wait_tick(50, n);
    cyc(3);
    reset = 1'b1;
    dir_btn_n = 1'b1;
    cyc(1);
    check("rst5_clock_div", clock_div, 0);
    check("rst5_Up_Down", Up_Down, 1);
    reset = 1'b0;
    c0 = ud_changes;
    cyc(60);
    check("rst5_no_toggle", ud_changes - c0, 0);
    check("rst5_dir", Up_Down, 1);

`ifdef SINGLE_STEP_EN
    // single step while parked, then ignored while running
    run = 1'b0;
    cyc(20);
    step_btn_n = 1'b0;
    hi = 0;
    tk = 0;
    repeat (50) begin
      cyc(1);
      if (tk == 0 && hi == 0 && n > 20) step_btn_n = 1'b1;
      hi += int'(clock_div);
      tk += int'(tick);
    end
    step_btn_n = 1'b1;
    cyc(20);
    check("step_high_cycles", hi, DH);
    check("step_one_tick", tk, 1);
    run = 1'b1;
    step_btn_n = 1'b0;
    cyc(20);
    step_btn_n = 1'b1;
    cyc(20);
`endif

    // randomized run, reset and button activity
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) run = ~run;
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        dir_btn_n = 1'b0;
        cyc($urandom_range(1, 3));
        dir_btn_n = 1'b1;
        cyc($urandom_range(1, 3));
      end
      dir_btn_n = 1'b0;
      cyc($urandom_range(1, 24));
      dir_btn_n = 1'b1;
      cyc($urandom_range(1, 24));
    end
    run = 1'b1;
    cyc(60);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
